ifm_load_sched: RTL and testbench

//  Load scheduler between cnn_ctrl and the on-chip buffers. It shares one DRAM read-burst port between
//  IFM row loads (from cnn_ctrl o_ifm_buf_req_load/o_ifm_buf_req_row) and filter-buffer loads.
//  For each load it issues the bursts, steers data beats into the IFM bank or the filter buffer,
//  and returns the q_ifm_buf_done / q_filter_buf_done pulses that cnn_ctrl consumes.

---
 rtl/ifm_load_sched_pkg.sv | 28 ++
 rtl/dma_burst_gen.sv | 51 +++++
 rtl/ifm_load_sched.sv | 155 +++++++++++++++
 tb/tb_ifm_load_sched.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifm_load_sched_pkg.sv
// Shared widths, FSM encoding and burst-length helper for the IFM/filter load scheduler.
package ifm_load_sched_pkg;

  localparam int W_SIZE         = 12;
  localparam int W_CHANNEL      = 8;
  localparam int W_ADDR         = 32;
  localparam int W_DATA         = 64;
  localparam int IFM_BUF_CNT    = 4;
  localparam int W_IFM_BUF      = 2;
  localparam int W_BUF_AW       = 12;
  localparam int MAX_BURST      = 16;
  localparam int W_LEN          = 6;
  localparam int W_WORDS        = W_SIZE + W_CHANNEL;
  localparam int BYTES_PER_WORD = W_DATA / 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CMD  = 2'd1,
    S_DATA = 2'd2,
    S_DONE = 2'd3
  } state_t;

  function automatic logic [W_LEN-1:0] burst_len(input logic [W_WORDS-1:0] remaining);
    if (remaining < W_WORDS'(MAX_BURST)) return W_LEN'(remaining);
    return W_LEN'(MAX_BURST);
  endfunction

endpackage

// File: rtl/dma_burst_gen.sv
// Splits one transfer (start address + word count) into read bursts and tracks beats per burst.
module dma_burst_gen
  import ifm_load_sched_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [W_ADDR-1:0]  start_addr,
  input  logic [W_WORDS-1:0] words,
  input  logic               cmd_fire,
  input  logic               beat,
  output logic [W_ADDR-1:0]  cmd_addr,
  output logic [W_LEN-1:0]   cmd_len,
  output logic               last_beat,
  output logic               all_done
);

  logic [W_WORDS-1:0] remaining;
  logic [W_LEN-1:0]   cur_len;
  logic [W_LEN-1:0]   beat_cnt;

  // remaining only moves on cmd_fire, so addr/len stay stable while a command waits for ready
  assign cmd_len   = burst_len(remaining);
  assign last_beat = beat && (beat_cnt == cur_len - W_LEN'(1));
  assign all_done  = (remaining == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_addr  <= '0;
      remaining <= '0;
      cur_len   <= '0;
      beat_cnt  <= '0;
    end else if (load) begin
      cmd_addr  <= start_addr;
      remaining <= words;
      cur_len   <= '0;
      beat_cnt  <= '0;
    end else begin
      if (cmd_fire) begin
        cmd_addr  <= cmd_addr + W_ADDR'(cmd_len) * W_ADDR'(BYTES_PER_WORD);
        remaining <= remaining - W_WORDS'(cmd_len);
        cur_len   <= cmd_len;
        beat_cnt  <= '0;
      end
      if (beat) begin
        beat_cnt <= last_beat ? '0 : beat_cnt + W_LEN'(1);
      end
    end
  end

endmodule

// File: rtl/ifm_load_sched.sv
// Arbitrates IFM-row and filter loads onto one DRAM read-burst port and steers beats to the buffers.
module ifm_load_sched
  import ifm_load_sched_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [W_SIZE-1:0]    q_width,
  input  logic [W_CHANNEL-1:0] q_channel,
  input  logic [W_ADDR-1:0]    q_ifm_base,
  input  logic [W_ADDR-1:0]    q_filter_base,
  input  logic [W_BUF_AW-1:0]  q_filter_words,
  input  logic                 q_ifm_req,
  input  logic [W_SIZE-1:0]    q_ifm_req_row,
  input  logic                 q_filter_req,
  output logic                 o_rd_cmd_valid,
  input  logic                 i_rd_cmd_ready,
  output logic [W_ADDR-1:0]    o_rd_cmd_addr,
  output logic [W_LEN-1:0]     o_rd_cmd_len,
  input  logic                 i_rd_data_valid,
  input  logic [W_DATA-1:0]    i_rd_data,
  output logic                 o_rd_data_ready,
  output logic                 o_ifm_we,
  output logic [W_IFM_BUF-1:0] o_ifm_bank,
  output logic                 o_filter_we,
  output logic [W_BUF_AW-1:0]  o_buf_waddr,
  output logic [W_DATA-1:0]    o_buf_wdata,
  output logic                 o_ifm_buf_done,
  output logic                 o_filter_buf_done,
  output logic                 o_busy,
  output logic                 o_err,
  output state_t               dbg_state
);

  state_t               state, state_nxt;
  logic                 filt_pend, ifm_pend, ifm_req_d, cur_is_ifm;
  logic [W_SIZE-1:0]    ifm_row;
  logic [W_IFM_BUF-1:0] cur_bank;
  logic [W_BUF_AW-1:0]  wcnt;
  logic                 take_filt, take_ifm, seq_load;
  logic [W_WORDS-1:0]   ifm_words, seq_words;
  logic [W_ADDR-1:0]    ifm_start, seq_addr;
  logic                 cmd_fire, beat, last_beat, all_done;
  logic                 ifm_rise, ifm_active;

  // Handshakes: a command or beat transfers on a rising clk edge where valid and ready are both 1;
  // the command holds addr/len until that edge, and only one command is outstanding at a time.
  assign cmd_fire   = o_rd_cmd_valid && i_rd_cmd_ready;
  assign beat       = o_rd_data_ready && i_rd_data_valid;
  assign ifm_rise   = q_ifm_req && !ifm_req_d;
  assign ifm_active = (state != S_IDLE) && cur_is_ifm;

  assign ifm_words = W_WORDS'(q_width) * W_WORDS'(q_channel);
  assign ifm_start = q_ifm_base
                   + W_ADDR'(ifm_row) * W_ADDR'(ifm_words) * W_ADDR'(BYTES_PER_WORD);
  // Filter wins whenever its flag is set, so selection can key off filt_pend directly
  assign seq_words = filt_pend ? W_WORDS'(q_filter_words) : ifm_words;
  assign seq_addr  = filt_pend ? q_filter_base : ifm_start;

  assign o_rd_cmd_valid    = (state == S_CMD);
  assign o_rd_data_ready   = (state == S_DATA);
  assign o_busy            = (state != S_IDLE);
  assign o_ifm_buf_done    = (state == S_DONE) && cur_is_ifm;
  assign o_filter_buf_done = (state == S_DONE) && !cur_is_ifm;
  assign dbg_state         = state;

  dma_burst_gen u_burst (
    .clk        (clk),
    .rst        (rst),
    .load       (seq_load),
    .start_addr (seq_addr),
    .words      (seq_words),
    .cmd_fire   (cmd_fire),
    .beat       (beat),
    .cmd_addr   (o_rd_cmd_addr),
    .cmd_len    (o_rd_cmd_len),
    .last_beat  (last_beat),
    .all_done   (all_done)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    take_filt = 1'b0;
    take_ifm  = 1'b0;
    seq_load  = 1'b0;
    case (state)
      S_IDLE: begin
        if (filt_pend || ifm_pend) begin
          take_filt = filt_pend;
          take_ifm  = !filt_pend;
          seq_load  = 1'b1;
          state_nxt = (seq_words == '0) ? S_DONE : S_CMD;
        end
      end
      S_CMD:   if (cmd_fire) state_nxt = S_DATA;
      S_DATA:  if (last_beat) state_nxt = all_done ? S_DONE : S_CMD;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      filt_pend <= 1'b0;
      ifm_pend  <= 1'b0;
      ifm_req_d <= 1'b0;
      ifm_row   <= '0;
      o_err     <= 1'b0;
    end else begin
      ifm_req_d <= q_ifm_req;
      if (q_filter_req)   filt_pend <= 1'b1;
      else if (take_filt) filt_pend <= 1'b0;
      // take_ifm implies ifm_pend, so a same-cycle edge lands in the error path, never the set path
      if (ifm_rise && !ifm_pend && !ifm_active) begin
        ifm_pend <= 1'b1;
        ifm_row  <= q_ifm_req_row;
      end else if (take_ifm) begin
        ifm_pend <= 1'b0;
      end
      if (ifm_rise && (ifm_pend || ifm_active)) o_err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_is_ifm  <= 1'b0;
      cur_bank    <= '0;
      wcnt        <= '0;
      o_ifm_we    <= 1'b0;
      o_filter_we <= 1'b0;
      o_ifm_bank  <= '0;
      o_buf_waddr <= '0;
      o_buf_wdata <= '0;
    end else begin
      o_ifm_we    <= beat && cur_is_ifm;
      o_filter_we <= beat && !cur_is_ifm;
      if (seq_load) begin
        cur_is_ifm <= take_ifm;
        cur_bank   <= ifm_row[W_IFM_BUF-1:0];
        wcnt       <= '0;
      end
      if (beat) begin
        o_buf_waddr <= wcnt;
        o_buf_wdata <= i_rd_data;
        o_ifm_bank  <= cur_is_ifm ? cur_bank : '0;
        wcnt        <= wcnt + W_BUF_AW'(1);
      end
    end
  end

endmodule

// File: tb/tb_ifm_load_sched.sv
// Directed bench for ifm_load_sched: DRAM responder, expected-queue scoreboard and output monitor.
`timescale 1ns/1ps
module tb_ifm_load_sched;
  import ifm_load_sched_pkg::*;

  localparam int WR_W = 2 + W_IFM_BUF + W_BUF_AW + W_DATA;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [W_SIZE-1:0]    q_width;
  logic [W_CHANNEL-1:0] q_channel;
  logic [W_ADDR-1:0]    q_ifm_base, q_filter_base;
  logic [W_BUF_AW-1:0]  q_filter_words;
  logic                 q_ifm_req, q_filter_req;
  logic [W_SIZE-1:0]    q_ifm_req_row;
  logic                 o_rd_cmd_valid, i_rd_cmd_ready;
  logic [W_ADDR-1:0]    o_rd_cmd_addr;
  logic [W_LEN-1:0]     o_rd_cmd_len;
  logic                 i_rd_data_valid, o_rd_data_ready;
  logic [W_DATA-1:0]    i_rd_data;
  logic                 o_ifm_we, o_filter_we;
  logic [W_IFM_BUF-1:0] o_ifm_bank;
  logic [W_BUF_AW-1:0]  o_buf_waddr;
  logic [W_DATA-1:0]    o_buf_wdata;
  logic                 o_ifm_buf_done, o_filter_buf_done, o_busy, o_err;
  state_t               dbg_state;

  logic [W_ADDR+W_LEN-1:0] exp_cmd_q[$];
  logic [WR_W-1:0]         exp_wr_q[$];
  logic [1:0]              exp_done_q[$];

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int wr_seen = 0;
  int ready_delay = 0;
  bit data_gap = 1'b0;

  always #5 clk = ~clk;

  ifm_load_sched dut (
    .clk(clk), .rst(rst), .q_width(q_width), .q_channel(q_channel),
    .q_ifm_base(q_ifm_base), .q_filter_base(q_filter_base), .q_filter_words(q_filter_words),
    .q_ifm_req(q_ifm_req), .q_ifm_req_row(q_ifm_req_row), .q_filter_req(q_filter_req),
    .o_rd_cmd_valid(o_rd_cmd_valid), .i_rd_cmd_ready(i_rd_cmd_ready),
    .o_rd_cmd_addr(o_rd_cmd_addr), .o_rd_cmd_len(o_rd_cmd_len),
    .i_rd_data_valid(i_rd_data_valid), .i_rd_data(i_rd_data), .o_rd_data_ready(o_rd_data_ready),
    .o_ifm_we(o_ifm_we), .o_ifm_bank(o_ifm_bank), .o_filter_we(o_filter_we),
    .o_buf_waddr(o_buf_waddr), .o_buf_wdata(o_buf_wdata),
    .o_ifm_buf_done(o_ifm_buf_done), .o_filter_buf_done(o_filter_buf_done),
    .o_busy(o_busy), .o_err(o_err), .dbg_state(dbg_state)
  );

  function automatic logic [W_DATA-1:0] beat_data(input logic [W_ADDR-1:0] a);
    return {32'hCAFE_0000, a};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_zero(input string name);
    check(name, {o_rd_cmd_valid, o_rd_cmd_addr, o_rd_cmd_len, o_rd_data_ready, o_ifm_we,
                 o_ifm_bank, o_filter_we, o_buf_waddr, o_buf_wdata, o_ifm_buf_done,
                 o_filter_buf_done, o_busy, o_err, dbg_state}, 128'd0);
  endtask

  task automatic expect_xfer(input bit is_ifm, input logic [W_IFM_BUF-1:0] bank,
                             input logic [W_ADDR-1:0] start, input int words, input bit with_cmds);
    logic [W_ADDR-1:0]    a;
    logic [W_IFM_BUF-1:0] wbank;
    int rem;
    int len;
    a = start;
    rem = words;
    wbank = is_ifm ? bank : 2'd0;
    if (with_cmds) begin
      while (rem > 0) begin
        len = (rem > MAX_BURST) ? MAX_BURST : rem;
        exp_cmd_q.push_back({a, W_LEN'(len)});
        a = a + W_ADDR'(len * 8);
        rem = rem - len;
      end
    end
    for (int k = 0; k < words; k++)
      exp_wr_q.push_back({~is_ifm, is_ifm, wbank, W_BUF_AW'(k), beat_data(start + W_ADDR'(k * 8))});
    exp_done_q.push_back({~is_ifm, is_ifm});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_filter(input int words, input logic [W_ADDR-1:0] base);
    q_filter_words = W_BUF_AW'(words);
    q_filter_base = base;
    q_filter_req = 1'b1;
    tick();
    q_filter_req = 1'b0;
  endtask

  task automatic raise_ifm(input logic [W_SIZE-1:0] row);
    q_ifm_req_row = row;
    q_ifm_req = 1'b1;
    tick();
    q_ifm_req = 1'b0;
  endtask

  task automatic wait_done(input int target, input string name);
    int n;
    n = 0;
    while (done_cnt < target && n < 5000) begin
      tick();
      n++;
    end
    check({name, "_done"}, done_cnt >= target, 1);
    repeat (3) tick();
    check({name, "_queues_empty"}, exp_cmd_q.size() + exp_wr_q.size() + exp_done_q.size(), 0);
  endtask

  // DRAM responder: drives on negedge from handshakes that completed at the previous posedge
  initial begin : mem_model
    logic [W_ADDR-1:0] m_addr, p_addr;
    logic [W_LEN-1:0]  p_len;
    int  m_left, stall;
    bit  p_cmd, p_beat, busy, gap;
    m_addr = '0; p_addr = '0; p_len = '0;
    m_left = 0; stall = 0; p_cmd = 0; p_beat = 0; busy = 0; gap = 0;
    i_rd_cmd_ready = 1'b0;
    i_rd_data_valid = 1'b0;
    i_rd_data = '0;
    forever begin
      @(negedge clk);
      if (p_beat) begin
        m_addr = m_addr + W_ADDR'(8);
        m_left--;
        if (m_left == 0) busy = 0;
      end
      if (p_cmd) begin
        busy = 1;
        m_addr = p_addr;
        m_left = int'(p_len);
      end
      if (rst) begin
        busy = 0;
        stall = 0;
      end
      if (o_rd_cmd_valid && !rst) begin
        if (stall < ready_delay) begin
          i_rd_cmd_ready = 1'b0;
          stall++;
        end else begin
          i_rd_cmd_ready = 1'b1;
        end
      end else begin
        i_rd_cmd_ready = 1'b0;
        stall = 0;
      end
      gap = data_gap ? !gap : 1'b0;
      i_rd_data_valid = busy && !gap;
      i_rd_data = busy ? beat_data(m_addr) : '0;
      p_cmd = o_rd_cmd_valid && i_rd_cmd_ready;
      p_addr = o_rd_cmd_addr;
      p_len = o_rd_cmd_len;
      p_beat = i_rd_data_valid && o_rd_data_ready;
    end
  end

  initial begin : monitor
    logic [WR_W-1:0]   wr_act;
    logic [W_ADDR-1:0] prev_addr;
    logic [W_LEN-1:0]  prev_len;
    bit prev_stall;
    prev_stall = 0; prev_addr = '0; prev_len = '0;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        prev_stall = 0;
      end else begin
        if (prev_stall)
          check("cmd_hold", {o_rd_cmd_valid, o_rd_cmd_addr, o_rd_cmd_len}, {1'b1, prev_addr, prev_len});
        prev_stall = o_rd_cmd_valid && !i_rd_cmd_ready;
        prev_addr = o_rd_cmd_addr;
        prev_len = o_rd_cmd_len;
        if (o_rd_cmd_valid && i_rd_cmd_ready) begin
          if (exp_cmd_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL cmd: unexpected command addr %0h len %0d", o_rd_cmd_addr, o_rd_cmd_len);
          end else begin
            check("cmd", {o_rd_cmd_addr, o_rd_cmd_len}, exp_cmd_q.pop_front());
          end
        end
        if (o_ifm_we || o_filter_we) begin
          wr_seen++;
          wr_act = {o_filter_we, o_ifm_we, o_ifm_bank, o_buf_waddr, o_buf_wdata};
          if (exp_wr_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL write: unexpected write %0h", wr_act);
          end else begin
            check("write", wr_act, exp_wr_q.pop_front());
          end
        end
        if (o_ifm_buf_done || o_filter_buf_done) begin
          done_cnt++;
          if (exp_done_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL done: unexpected done filter=%0b ifm=%0b", o_filter_buf_done, o_ifm_buf_done);
          end else begin
            check("done", {o_filter_buf_done, o_ifm_buf_done}, exp_done_q.pop_front());
          end
        end
      end
    end
  end

  initial begin : stimulus
    int n;
    int w0;
    rst = 1'b1;
    q_width = '0; q_channel = '0; q_ifm_base = 32'h0002_0000; q_filter_base = '0;
    q_filter_words = '0; q_ifm_req = 1'b0; q_ifm_req_row = '0; q_filter_req = 1'b0;
    repeat (3) tick();
    check_zero("reset_outputs");
    rst = 1'b0;
    tick();

    // 1: filter 64 words at 0x1000, four 16-beat bursts, plus request-to-command latency
    exp_cmd_q.push_back({32'h0000_1000, 6'd16});
    exp_cmd_q.push_back({32'h0000_1080, 6'd16});
    exp_cmd_q.push_back({32'h0000_1100, 6'd16});
    exp_cmd_q.push_back({32'h0000_1180, 6'd16});
    expect_xfer(1'b0, 2'd0, 32'h0000_1000, 64, 1'b0);
    pulse_filter(64, 32'h0000_1000);
    check("latency_edge_t", o_rd_cmd_valid, 0);
    tick();
    check("latency_edge_t1", {o_rd_cmd_valid, o_busy}, 2'b11);
    wait_done(1, "t1");

    // 2: IFM row 5, 256x4 words -> start base+0xA000, bank 1
    q_width = 12'd256; q_channel = 8'd4;
    expect_xfer(1'b1, 2'd1, 32'h0002_A000, 1024, 1'b1);
    raise_ifm(12'd5);
    wait_done(2, "t2");

    // 3: simultaneous requests, filter served first
    q_width = 12'd3; q_channel = 8'd2;
    expect_xfer(1'b0, 2'd0, 32'h0000_4000, 20, 1'b1);
    expect_xfer(1'b1, 2'd2, 32'h0002_0060, 6, 1'b1);
    q_filter_words = 12'd20; q_filter_base = 32'h0000_4000;
    q_ifm_req_row = 12'd2;
    q_filter_req = 1'b1; q_ifm_req = 1'b1;
    tick();
    q_filter_req = 1'b0; q_ifm_req = 1'b0;
    wait_done(4, "t3");

    // 4: ready stalled 10 cycles, data every other cycle
    ready_delay = 10; data_gap = 1'b1;
    expect_xfer(1'b0, 2'd0, 32'h0000_5000, 24, 1'b1);
    pulse_filter(24, 32'h0000_5000);
    wait_done(5, "t4");
    ready_delay = 0; data_gap = 1'b0;

    // 5a: second IFM edge while the first is still pending is dropped and flagged
    check("err_clear", o_err, 0);
    q_width = 12'd2; q_channel = 8'd2;
    expect_xfer(1'b0, 2'd0, 32'h0000_6000, 8, 1'b1);
    expect_xfer(1'b1, 2'd1, 32'h0002_0020, 4, 1'b1);
    pulse_filter(8, 32'h0000_6000);
    raise_ifm(12'd1);
    tick();
    raise_ifm(12'd3);
    check("err_set", o_err, 1);
    wait_done(7, "t5a");

    // 5b: zero-width row completes without any command
    q_width = 12'd0; q_channel = 8'd4;
    exp_done_q.push_back(2'b01);
    raise_ifm(12'd0);
    wait_done(8, "t5b");
    check("t5b_idle_err_sticky", {o_busy, o_err}, 2'b01);

    // 6: reset mid-DATA, then a fresh load restarts at waddr 0
    expect_xfer(1'b0, 2'd0, 32'h0000_7000, 32, 1'b1);
    pulse_filter(32, 32'h0000_7000);
    w0 = wr_seen;
    n = 0;
    while (wr_seen < w0 + 5 && n < 200) begin
      tick();
      n++;
    end
    check("t6_writes_started", wr_seen >= w0 + 5, 1);
    rst = 1'b1;
    exp_cmd_q.delete();
    exp_wr_q.delete();
    exp_done_q.delete();
    tick();
    check_zero("t6_reset_outputs");
    rst = 1'b0;
    repeat (4) tick();
    check("t6_quiet_after_reset", {o_busy, o_rd_data_ready, o_ifm_we, o_filter_we}, 4'b0000);
    expect_xfer(1'b0, 2'd0, 32'h0000_7800, 8, 1'b1);
    pulse_filter(8, 32'h0000_7800);
    wait_done(9, "t6");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
